// File: rtl/f16_dot_acc_seq.sv
// ---------------------------------------------------------------------------
// f16_dot_acc_seq
//   Streaming dot-product sequencer wrapped around an external, purely
//   combinational f16 fused multiply-add (f16_fmac_normal_no_grs).
//   Each accepted operand pair is folded as acc = x*y + acc. A vector ends on
//   in_last or when MAX_LEN elements have been folded; the finished sum is
//   then held on a valid/ready output port until it is consumed.
//
//   Optional build macro: F16_DOT_ACC_SKIP_ZERO_EN
//     When defined, a pair whose x or y exponent field is zero (zero or
//     subnormal, outside the FMAC's normal range) is counted but does not
//     update the accumulator; the FMAC result is ignored for that pair.
// ---------------------------------------------------------------------------
module f16_dot_acc_seq #(
  parameter int          MAX_LEN  = 16,
  parameter int          CNT_W    = $clog2(MAX_LEN + 1),
  parameter logic [15:0] ACC_INIT = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  // operand stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_y,
  input  logic             in_last,
  // external FMAC datapath
  output logic [15:0]      fmac_x,
  output logic [15:0]      fmac_y,
  output logic [15:0]      fmac_z,
  input  logic [15:0]      fmac_result,
  // result stream
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             err_overlen
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state_reg;
  logic [15:0]      acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic [15:0]      sum_reg;
  logic [CNT_W-1:0] out_count_reg;
  logic             err_reg;

  logic             accept;
  logic [CNT_W-1:0] count_next;
  logic             hit_max;
  logic             vec_end;
  logic [15:0]      fold_value;

  // The FMAC sees the live operands; its z input is the running sum, or the
  // seed value on the first element of a vector.
  always_comb begin
    fmac_x = in_x;
    fmac_y = in_y;
    fmac_z = (count_reg == '0) ? ACC_INIT : acc_reg;
  end

  // Handshake decode and the value folded into the accumulator this cycle.
  always_comb begin
    in_ready   = (state_reg == ST_ACCUM);
    out_valid  = (state_reg == ST_HOLD);
    accept     = in_valid && in_ready;
    count_next = count_reg + ONE_CNT;
    hit_max    = (count_next == MAX_CNT);
    vec_end    = in_last || hit_max;
`ifdef F16_DOT_ACC_SKIP_ZERO_EN
    // Zero/subnormal operands would leave the FMAC's normal-only range, so
    // the pair contributes nothing and the current sum is carried forward.
    if ((in_x[14:10] == 5'd0) || (in_y[14:10] == 5'd0)) begin
      fold_value = fmac_z;
    end else begin
      fold_value = fmac_result;
    end
`else
    fold_value = fmac_result;
`endif
  end

  // Sequencer: accumulate in ACCUM, present the finished sum in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_ACCUM;
      acc_reg       <= ACC_INIT;
      count_reg     <= '0;
      sum_reg       <= 16'h0000;
      out_count_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_ACCUM: begin
          if (accept) begin
            if (vec_end) begin
              // Capture the finished vector and re-seed for the next one.
              sum_reg       <= fold_value;
              out_count_reg <= count_next;
              err_reg       <= hit_max && !in_last;
              acc_reg       <= ACC_INIT;
              count_reg     <= '0;
              state_reg     <= ST_HOLD;
            end else begin
              acc_reg   <= fold_value;
              count_reg <= count_next;
            end
          end
        end
        ST_HOLD: begin
          // Result registers are untouched here, so they stay stable under
          // backpressure. No new pair is taken in the handshake cycle.
          if (out_ready) begin
            state_reg <= ST_ACCUM;
          end
        end
        default: begin
          state_reg <= ST_ACCUM;
        end
      endcase
    end
  end

  assign out_sum     = sum_reg;
  assign out_count   = out_count_reg;
  assign err_overlen = err_reg;

endmodule

// File: tb/tb_f16_dot_acc_seq.sv
// ---------------------------------------------------------------------------
// Testbench for f16_dot_acc_seq. Two instances: u0 with MAX_LEN=16 and u1
// with MAX_LEN=4. The FMAC on each instance is a real-arithmetic model of a
// normal-only, truncating f16 multiply-add. A scoreboard queue per instance
// holds the expected {sum, count, err} of each finished vector.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_f16_dot_acc_seq;

  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid_s  [2];
  logic          in_ready_s  [2];
  logic [15:0]   in_x_s      [2];
  logic [15:0]   in_y_s      [2];
  logic          in_last_s   [2];
  logic [15:0]   fmac_x_s    [2];
  logic [15:0]   fmac_y_s    [2];
  logic [15:0]   fmac_z_s    [2];
  logic [15:0]   fmac_res_s  [2];
  logic          out_valid_s [2];
  logic          out_ready_s [2];
  logic [15:0]   out_sum_s   [2];
  logic [CW-1:0] out_count_s [2];
  logic [2:0]    out_count1;
  logic          err_s       [2];

  typedef struct packed {
    logic [15:0]   sum;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int checks = 0;
  int errors = 0;

  // reference model state per instance
  logic [15:0] m_acc [2];
  int          m_cnt [2];
  int          m_max [2];

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [15:0] h);
    real r;
    if (h[14:10] == 5'd0) return 0.0;
    r = pow2(int'(h[14:10]) - 15) * (1.0 + real'(h[9:0]) / 1024.0);
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2f(input real r);
    real a;
    int e;
    int be;
    int m;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    be = e + 15;
    if (be <= 0)  return {s, 15'h0000};
    if (be >= 31) return {s, 5'h1f, 10'h000};
    m = $rtoi((a - 1.0) * 1024.0);
    return {s, be[4:0], m[9:0]};
  endfunction

  function automatic logic [15:0] fmac(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z);
    return r2f(f2r(x) * f2r(y) + f2r(z));
  endfunction

  // combinational FMAC models on each instance
  always_comb begin
    fmac_res_s[0] = fmac(fmac_x_s[0], fmac_y_s[0], fmac_z_s[0]);
    fmac_res_s[1] = fmac(fmac_x_s[1], fmac_y_s[1], fmac_z_s[1]);
  end

  f16_dot_acc_seq #(.MAX_LEN(16), .ACC_INIT(16'h0000)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .in_x(in_x_s[0]), .in_y(in_y_s[0]), .in_last(in_last_s[0]),
    .fmac_x(fmac_x_s[0]), .fmac_y(fmac_y_s[0]), .fmac_z(fmac_z_s[0]),
    .fmac_result(fmac_res_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .out_sum(out_sum_s[0]), .out_count(out_count_s[0]), .err_overlen(err_s[0])
  );

  f16_dot_acc_seq #(.MAX_LEN(4), .ACC_INIT(16'h0000)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .in_x(in_x_s[1]), .in_y(in_y_s[1]), .in_last(in_last_s[1]),
    .fmac_x(fmac_x_s[1]), .fmac_y(fmac_y_s[1]), .fmac_z(fmac_z_s[1]),
    .fmac_result(fmac_res_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .out_sum(out_sum_s[1]), .out_count(out_count1), .err_overlen(err_s[1])
  );
  assign out_count_s[1] = CW'(out_count1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 16'h0000;
      m_cnt[i] = 0;
    end
  endtask

  // Drive one pair for one cycle; model the fold and push on vector end.
  task automatic send_pair(input int inst, input logic [15:0] x, input logic [15:0] y,
                           input logic last);
    logic [15:0] z;
    logic [15:0] r;
    exp_t e;
    in_valid_s[inst] = 1'b1;
    in_x_s[inst]     = x;
    in_y_s[inst]     = y;
    in_last_s[inst]  = last;
    checks++;
    if (in_ready_s[inst] !== 1'b1) begin
      errors++;
      $display("FAIL send_ready inst%0d got %b need 1", inst, in_ready_s[inst]);
    end
    z = (m_cnt[inst] == 0) ? 16'h0000 : m_acc[inst];
    r = fmac(x, y, z);
`ifdef F16_DOT_ACC_SKIP_ZERO_EN
    if (x[14:10] == 5'd0 || y[14:10] == 5'd0) r = z;
`endif
    m_cnt[inst]++;
    if (last || m_cnt[inst] == m_max[inst]) begin
      e.sum = r;
      e.cnt = CW'(m_cnt[inst]);
      e.err = (m_cnt[inst] == m_max[inst]) && !last;
      if (inst == 0) sb0.push_back(e); else sb1.push_back(e);
      m_cnt[inst] = 0;
      m_acc[inst] = 16'h0000;
    end else begin
      m_acc[inst] = r;
    end
    $display("pair inst%0d x=%h y=%h last=%b", inst, x, y, last);
    tick();
    in_valid_s[inst] = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then compare against the scoreboard head.
  task automatic check_out(input int inst);
    exp_t e;
    int n;
    n = 0;
    while (out_valid_s[inst] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid_s[inst] !== 1'b1) begin
      errors++;
      $display("FAIL out_timeout inst%0d got out_valid=%b need 1", inst, out_valid_s[inst]);
      return;
    end
    if ((inst == 0 && sb0.size() == 0) || (inst == 1 && sb1.size() == 0)) begin
      errors++;
      $display("FAIL sb_empty inst%0d got unexpected output sum=%h", inst, out_sum_s[inst]);
      return;
    end
    e = (inst == 0) ? sb0.pop_front() : sb1.pop_front();
    if (out_sum_s[inst] !== e.sum || out_count_s[inst] !== e.cnt || err_s[inst] !== e.err) begin
      errors++;
      $display("FAIL sb_result inst%0d got sum=%h cnt=%0d err=%b need sum=%h cnt=%0d err=%b",
               inst, out_sum_s[inst], out_count_s[inst], err_s[inst], e.sum, e.cnt, e.err);
    end
    $display("result inst%0d sum=%h cnt=%0d err=%b", inst, out_sum_s[inst],
             out_count_s[inst], err_s[inst]);
  endtask

  task automatic expect_out(input string name, input logic [15:0] sum,
                            input int cnt, input logic err);
    checks++;
    if (out_sum_s[0] !== sum || out_count_s[0] !== CW'(cnt) || err_s[0] !== err) begin
      errors++;
      $display("FAIL %s got sum=%h cnt=%0d err=%b need sum=%h cnt=%0d err=%b", name,
               out_sum_s[0], out_count_s[0], err_s[0], sum, cnt, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid_s[i] !== 1'b0 || out_sum_s[i] !== 16'h0 || out_count_s[i] !== '0 ||
          err_s[i] !== 1'b0 || in_ready_s[i] !== 1'b1 || fmac_z_s[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset inst%0d got v=%b sum=%h cnt=%0d err=%b rdy=%b z=%h need 0/0/0/0/1/0",
                 i, out_valid_s[i], out_sum_s[i], out_count_s[i], err_s[i], in_ready_s[i],
                 fmac_z_s[i]);
      end
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_two_pair();
    out_ready_s[0] = 1'b1;
    send_pair(0, 16'h3C00, 16'h4000, 1'b0);
    checks++;
    if (fmac_z_s[0] !== 16'h4000) begin
      errors++;
      $display("FAIL two_pair_z got %h need 4000", fmac_z_s[0]);
    end
    send_pair(0, 16'h4000, 16'h4000, 1'b1);
    checks++;
    if (out_valid_s[0] !== 1'b1 || in_ready_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL two_pair_latency got v=%b rdy=%b need v=1 rdy=0", out_valid_s[0],
               in_ready_s[0]);
    end
    expect_out("two_pair_sum", 16'h4600, 2, 1'b0);
    check_out(0);
    tick();
    checks++;
    if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL two_pair_release got v=%b rdy=%b need v=0 rdy=1", out_valid_s[0],
               in_ready_s[0]);
    end
  endtask

  task automatic test_single();
    out_ready_s[0] = 1'b1;
    send_pair(0, 16'h4200, 16'h3800, 1'b1);
    expect_out("single_sum", 16'h3E00, 1, 1'b0);
    check_out(0);
    tick();
    checks++;
    if (out_valid_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle got out_valid=%b need 0", out_valid_s[0]);
    end
  endtask

  task automatic test_backpressure();
    out_ready_s[0] = 1'b0;
    send_pair(0, 16'h3C00, 16'h4000, 1'b0);
    send_pair(0, 16'h4000, 16'h4000, 1'b1);
    // offered but must not be accepted while holding
    in_valid_s[0] = 1'b1;
    in_x_s[0]     = 16'h4400;
    in_y_s[0]     = 16'h4400;
    in_last_s[0]  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid_s[0] !== 1'b1 || in_ready_s[0] !== 1'b0 || out_sum_s[0] !== 16'h4600 ||
          out_count_s[0] !== CW'(2)) begin
        errors++;
        $display("FAIL backpressure_hold c%0d got v=%b rdy=%b sum=%h cnt=%0d need 1/0/4600/2",
                 c, out_valid_s[0], in_ready_s[0], out_sum_s[0], out_count_s[0]);
      end
      tick();
    end
    in_valid_s[0] = 1'b0;
    check_out(0);
    out_ready_s[0] = 1'b1;
    tick();
    checks++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release got rdy=%b v=%b need 1/0", in_ready_s[0],
               out_valid_s[0]);
    end
    send_pair(0, 16'h3C00, 16'h3C00, 1'b1);
    expect_out("backpressure_next", 16'h3C00, 1, 1'b0);
    check_out(0);
    tick();
  endtask

  task automatic test_overlen();
    out_ready_s[1] = 1'b1;
    for (int i = 0; i < 4; i++) send_pair(1, 16'h3C00, 16'h3C00, 1'b0);
    checks++;
    if (out_valid_s[1] !== 1'b1 || out_sum_s[1] !== 16'h4400 || out_count_s[1] !== CW'(4) ||
        err_s[1] !== 1'b1) begin
      errors++;
      $display("FAIL overlen got v=%b sum=%h cnt=%0d err=%b need 1/4400/4/1", out_valid_s[1],
               out_sum_s[1], out_count_s[1], err_s[1]);
    end
    check_out(1);
    tick();
    send_pair(1, 16'h4000, 16'h3C00, 1'b1);
    checks++;
    if (out_sum_s[1] !== 16'h4000 || out_count_s[1] !== CW'(1) || err_s[1] !== 1'b0) begin
      errors++;
      $display("FAIL overlen_next got sum=%h cnt=%0d err=%b need 4000/1/0", out_sum_s[1],
               out_count_s[1], err_s[1]);
    end
    check_out(1);
    tick();
  endtask

  task automatic test_reset_mid_vector();
    out_ready_s[0] = 1'b1;
    send_pair(0, 16'h4000, 16'h4000, 1'b0);
    rst = 1'b1;
    tick();
    expect_out("reset_during", 16'h0000, 0, 1'b0);
    checks++;
    if (out_valid_s[0] !== 1'b0 || fmac_z_s[0] !== 16'h0000) begin
      errors++;
      $display("FAIL reset_during_state got v=%b z=%h need 0/0000", out_valid_s[0],
               fmac_z_s[0]);
    end
    rst = 1'b0;
    model_reset();
    tick();
    expect_out("reset_after", 16'h0000, 0, 1'b0);
    send_pair(0, 16'h3C00, 16'h3C00, 1'b1);
    expect_out("reset_mid_sum", 16'h3C00, 1, 1'b0);
    check_out(0);
    tick();
  endtask

  task automatic test_zero_operand();
    out_ready_s[0] = 1'b1;
    send_pair(0, 16'h0000, 16'h4000, 1'b0);
    send_pair(0, 16'h3C00, 16'h3C00, 1'b1);
    checks++;
    if (out_count_s[0] !== CW'(2)) begin
      errors++;
      $display("FAIL zero_count got %0d need 2", out_count_s[0]);
    end
    check_out(0);
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready_s[0] = 1'b1;
    for (int v = 0; v < 3; v++) begin
      send_pair(0, 16'h3C00 + 16'(v * 16'h0100), 16'h4000, 1'b0);
      send_pair(0, 16'h3800, 16'h4000 + 16'(v * 16'h0080), 1'b0);
      send_pair(0, 16'h4000, 16'h3C00, 1'b1);
      check_out(0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    m_max[0] = 16;
    m_max[1] = 4;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid_s[i]  = 1'b0;
      in_x_s[i]      = 16'h0;
      in_y_s[i]      = 16'h0;
      in_last_s[i]   = 1'b0;
      out_ready_s[i] = 1'b1;
    end
    test_reset();
    test_two_pair();
    test_single();
    test_backpressure();
    test_overlen();
    test_reset_mid_vector();
    test_zero_operand();
    test_back_to_back();
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d/%0d need 0/0", sb0.size(), sb1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
